// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the spi_con_multi controller
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;

  typedef logic [1:0] spi_mode_t;
  localparam int CPOL_IDX = 1;
  localparam int CPHA_IDX = 0;

  // A single chip select still needs a 1-bit index port.
  function automatic int spi_csw(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period edge strobe generator for the SPI clock
module spi_clk_div #(
  parameter  int HALF = 2,
  localparam int CW   = $clog2(HALF + 1)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic strobe_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero while disabled so every enable window starts a fresh half period.
  always_comb begin
    cnt_d    = '0;
    strobe_o = 1'b0;
    if (en_i) begin
      if (cnt_q == CW'(HALF - 1)) begin
        strobe_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_con_multi.sv
// rtl/spi_con_multi.sv - full-duplex multi-CS SPI controller, all four CPOL/CPHA modes
// Define SPI_LSB_FIRST_EN for LSB-first transmit/receive; MSB-first otherwise.
module spi_con_multi
  import spi_pkg::*;
#(
  parameter  int DATA_WIDTH      = 8,
  parameter  int DATA_CLK_PERIOD = 4,
  parameter  int NUM_CS          = 4,
  localparam int CSW             = spi_csw(NUM_CS)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger_in,
  input  logic [CSW-1:0]        chip_sel_in,
  input  logic [1:0]            mode_in,
  input  logic                  cipo_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  busy_out,
  output logic                  copi_out,
  output logic                  dclk_out,
  output logic [NUM_CS-1:0]     cs_out
);

  localparam int HALF = DATA_CLK_PERIOD / 2;
  localparam int ECW  = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CSW:0] NUM_CS_W = (CSW + 1)'(NUM_CS);

  spi_state_t            state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [NUM_CS-1:0]     cs_q, cs_d;
  logic                  dclk_q, dclk_d;
  logic                  copi_q, copi_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic [ECW-1:0]        edge_q, edge_d;

  logic                  strobe;
  logic                  accept;
  logic [ECW-1:0]        edge_k;
  logic                  leading;
  logic                  cpha;

  logic                  first_bit;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] tx_shifted;
  logic [DATA_WIDTH-1:0] rx_shifted;

`ifdef SPI_LSB_FIRST_EN
  assign first_bit  = data_in[0];
  assign next_bit   = tx_q[1];
  assign tx_shifted = tx_q >> 1;
  assign rx_shifted = {cipo_in, rx_q[DATA_WIDTH-1:1]};
`else
  assign first_bit  = data_in[DATA_WIDTH-1];
  assign next_bit   = tx_q[DATA_WIDTH-2];
  assign tx_shifted = tx_q << 1;
  assign rx_shifted = {rx_q[DATA_WIDTH-2:0], cipo_in};
`endif

  assign busy_out = (state_q != IDLE);
  assign accept   = trigger_in && !busy_out && ({1'b0, chip_sel_in} < NUM_CS_W);

  spi_clk_div #(.HALF(HALF)) u_clk_div (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .en_i    (busy_out),
    .strobe_o(strobe)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cs_d    = cs_q;
    dclk_d  = dclk_q;
    copi_d  = copi_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    edge_d  = edge_q;
    edge_k  = edge_q + ECW'(1);
    leading = edge_k[0];
    cpha    = mode_q[CPHA_IDX];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          mode_d  = mode_in;
          dclk_d  = mode_in[CPOL_IDX];
          tx_d    = data_in;
          copi_d  = first_bit;
          edge_d  = '0;
          for (int i = 0; i < NUM_CS; i++) begin
            cs_d[i] = (CSW'(i) != chip_sel_in);
          end
        end
      end
      SETUP, XFER: begin
        // Edge k is the one being produced by this strobe; odd k are leading.
        if (strobe) begin
          dclk_d  = ~dclk_q;
          edge_d  = edge_k;
          state_d = (edge_k == ECW'(2 * DATA_WIDTH)) ? HOLD : XFER;
          if (leading != cpha) begin
            rx_d = rx_shifted;
          end
          if ((!cpha && !leading && edge_k != ECW'(2 * DATA_WIDTH)) ||
              ( cpha &&  leading && edge_k != ECW'(1))) begin
            tx_d   = tx_shifted;
            copi_d = next_bit;
          end
        end
      end
      HOLD: begin
        if (strobe) begin
          state_d = IDLE;
          cs_d    = '1;
          dclk_d  = mode_q[CPOL_IDX];
          dout_d  = rx_q;
          valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      mode_q  <= '0;
      cs_q    <= '1;
      dclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cs_q    <= cs_d;
      dclk_q  <= dclk_d;
      copi_q  <= copi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      edge_q  <= edge_d;
    end
  end

  assign cs_out         = cs_q;
  assign dclk_out       = dclk_q;
  assign copi_out       = copi_q;
  assign data_out       = dout_q;
  assign data_valid_out = valid_q;

endmodule

// File: tb/tb_spi_con_multi.sv
// tb/tb_spi_con_multi.sv - directed self-checking bench for spi_con_multi
module tb_spi_con_multi;

  localparam int DW  = 8;
  localparam int NCS = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  data_in;
  logic           trigger;
  logic [1:0]     chip_sel;
  logic [1:0]     mode;
  logic           cipo_in;
  logic           cipo_drv;
  bit             loop_en;
  logic [DW-1:0]  data_out;
  logic           data_valid_out;
  logic           busy_out;
  logic           copi_out;
  logic           dclk_out;
  logic [NCS-1:0] cs_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  assign cipo_in = loop_en ? copi_out : cipo_drv;

  always #5 clk = ~clk;

  spi_con_multi #(.DATA_WIDTH(DW), .DATA_CLK_PERIOD(4), .NUM_CS(NCS)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .data_in       (data_in),
    .trigger_in    (trigger),
    .chip_sel_in   (chip_sel),
    .mode_in       (mode),
    .cipo_in       (cipo_in),
    .data_out      (data_out),
    .data_valid_out(data_valid_out),
    .busy_out      (busy_out),
    .copi_out      (copi_out),
    .dclk_out      (dclk_out),
    .cs_out        (cs_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bit i of the wire order (i=0 goes first on the bus).
  function automatic logic bitof(input logic [7:0] w, input int i);
    if (i < 0 || i > 7) return 1'b0;
`ifdef SPI_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer accepted this cycle and plays the peripheral role for 60 cycles.
  task automatic xfer(input logic [7:0] d, input logic [1:0] sel, input logic [1:0] m,
                      input bit lp, input logic [7:0] rxw,
                      output int cs_low, output int vlat, output int vcnt,
                      output logic [7:0] tx_seen, output bit other_low,
                      output logic first_copi, output logic busy1, output logic dclk1);
    logic prev;
    logic leading;
    int   shift_n;
    cs_low = 0; vlat = 0; vcnt = 0; tx_seen = '0; other_low = 0; shift_n = 0;
    data_in = d; chip_sel = sel; mode = m; loop_en = lp; cipo_drv = bitof(rxw, 0);
    trigger = 1'b1;
    step();
    trigger = 1'b0; data_in = ~d; mode = ~m; chip_sel = sel + 2'd1;
    first_copi = copi_out; busy1 = busy_out; dclk1 = dclk_out; prev = dclk_out;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cs_out[sel] === 1'b0) cs_low++;
      for (int i = 0; i < NCS; i++) if (i != int'(sel) && cs_out[i] !== 1'b1) other_low = 1;
      if (data_valid_out === 1'b1) begin
        vcnt++;
        if (vlat == 0) vlat = cyc;
      end
      if (dclk_out !== prev) begin
        leading = (prev == m[1]);
        if (leading != m[0]) begin
`ifdef SPI_LSB_FIRST_EN
          tx_seen = {copi_out, tx_seen[7:1]};
`else
          tx_seen = {tx_seen[6:0], copi_out};
`endif
        end else begin
          shift_n++;
          cipo_drv = bitof(rxw, m[0] ? shift_n - 1 : shift_n);
        end
      end
      prev = dclk_out;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cs_low, vlat, vcnt, lat;
    logic [7:0] tx_seen;
    bit         other_low, seen_busy, seen_cs;
    logic       first_copi, busy1, dclk1;
    logic [NCS-1:0] cs_prev;

    rst_n = 1'b0; data_in = '0; trigger = 1'b0; chip_sel = '0; mode = '0;
    cipo_drv = 1'b0; loop_en = 0;
    repeat (3) step();
    chk("rst_cs", cs_out, 3'b111);
    chk("rst_dclk", dclk_out, 0);
    chk("rst_copi", copi_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid_out, 0);
    chk("rst_busy", busy_out, 0);
    rst_n = 1'b1;
    step();

    // Mode 0 loopback, 0xA5 on CS0.
    xfer(8'hA5, 2'd0, 2'b00, 1, 8'h00, cs_low, vlat, vcnt, tx_seen, other_low, first_copi, busy1, dclk1);
    chk("m0_busy_t1", busy1, 1);
    chk("m0_dclk_t1", dclk1, 0);
    chk("m0_first_copi", first_copi, 1);
    chk("m0_cs_low", cs_low, 34);
    chk("m0_valid_lat", vlat, 35);
    chk("m0_valid_cnt", vcnt, 1);
    chk("m0_data", data_out, 8'hA5);
    chk("m0_tx", tx_seen, 8'hA5);
    chk("m0_other_cs", other_low, 0);
    chk("m0_busy_end", busy_out, 0);

    // Mode 3 on CS2 with peripheral returning 0xC3.
    xfer(8'h3C, 2'd2, 2'b11, 0, 8'hC3, cs_low, vlat, vcnt, tx_seen, other_low, first_copi, busy1, dclk1);
    chk("m3_dclk_t1", dclk1, 1);
    chk("m3_dclk_idle", dclk_out, 1);
    chk("m3_first_copi", first_copi, 0);
    chk("m3_data", data_out, 8'hC3);
    chk("m3_tx", tx_seen, 8'h3C);
    chk("m3_cs_low", cs_low, 34);
    chk("m3_other_cs", other_low, 0);
    chk("m3_valid_lat", vlat, 35);

    // Out-of-range chip select is ignored, mode not latched.
    chip_sel = 2'd3; mode = 2'b00; data_in = 8'hFF; trigger = 1'b1;
    step();
    trigger = 1'b0;
    seen_busy = 0; seen_cs = 0;
    repeat (40) begin
      if (busy_out !== 1'b0) seen_busy = 1;
      if (cs_out !== 3'b111) seen_cs = 1;
      step();
    end
    chk("oor_busy", seen_busy, 0);
    chk("oor_cs", seen_cs, 0);
    chk("oor_dclk", dclk_out, 1);

    // Mid-transfer trigger ignored; trigger in valid cycle starts the next one.
    data_in = 8'h5A; chip_sel = 2'd1; mode = 2'b01; loop_en = 1; trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (9) step();
    data_in = 8'hFF; chip_sel = 2'd0; mode = 2'b00; trigger = 1'b1;
    step();
    trigger = 1'b0;
    lat = 11; cs_prev = cs_out;
    while (data_valid_out !== 1'b1 && lat < 100) begin
      cs_prev = cs_out;
      step();
      lat++;
    end
    chk("mid_valid_lat", lat, 35);
    chk("mid_data", data_out, 8'h5A);
    chk("mid_cs_before", cs_prev, 3'b101);
    chk("b2b_cs_valid", cs_out, 3'b111);
    data_in = 8'h96; chip_sel = 2'd1; mode = 2'b00; trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("b2b_busy", busy_out, 1);
    chk("b2b_cs_low", cs_out, 3'b101);
    lat = 1;
    while (data_valid_out !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    chk("b2b_valid_lat", lat, 35);
    chk("b2b_data", data_out, 8'h96);

    // Asynchronous reset during XFER.
    step();
    data_in = 8'hE7; chip_sel = 2'd0; mode = 2'b00; loop_en = 1; trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (12) step();
    chk("ar_busy_before", busy_out, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_cs", cs_out, 3'b111);
    chk("ar_busy", busy_out, 0);
    chk("ar_data", data_out, 0);
    chk("ar_copi", copi_out, 0);
    step();
    step();
    rst_n = 1'b1;
    vcnt = 0;
    repeat (50) begin
      if (data_valid_out !== 1'b0) vcnt++;
      step();
    end
    chk("ar_no_valid", vcnt, 0);
    xfer(8'h81, 2'd0, 2'b00, 1, 8'h00, cs_low, vlat, vcnt, tx_seen, other_low, first_copi, busy1, dclk1);
    chk("ar_after_data", data_out, 8'h81);
    chk("ar_after_lat", vlat, 35);

    // Bit order: 0x01 leads with a 1 only when LSB-first.
    xfer(8'h01, 2'd1, 2'b00, 1, 8'h00, cs_low, vlat, vcnt, tx_seen, other_low, first_copi, busy1, dclk1);
`ifdef SPI_LSB_FIRST_EN
    chk("ord_first_copi", first_copi, 1);
`else
    chk("ord_first_copi", first_copi, 0);
`endif
    chk("ord_data", data_out, 8'h01);
    chk("ord_tx", tx_seen, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_con_multi.md
# spi_con_multi

Parametrised full-duplex SPI controller: the successor to our transmit-only SPI generator. It shifts a DATA_WIDTH word out on copi_out while capturing cipo_in. It supports all four CPOL/CPHA modes, selected per transaction, and drives one of NUM_CS active-low chip selects. It sits between FPGA-side logic (trigger/valid handshake) and external SPI peripherals such as ADCs, DACs and sensors.

## Interface
- DATA_WIDTH, 8: bits per transaction, ≥2.
- DATA_CLK_PERIOD, 4: system cycles per SPI clock period. Must be even and ≥2. HALF = DATA_CLK_PERIOD/2.
- NUM_CS, 4: number of chip-select lines, ≥1. CSW = max(1, $clog2(NUM_CS)).
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  word to transmit; latched on accept.
- trigger_in  input  1  start request; accepted only when busy_out=0.
- chip_sel_in  input  CSW  target chip-select index; latched on accept.
- mode_in  input  2  {CPOL,CPHA}; latched on accept.
- cipo_in  input  1  serial data from the peripheral.
- data_out  output  DATA_WIDTH  last received word; held until the next completion.
- data_valid_out  output  1  one-cycle pulse when data_out updates.
- busy_out  output  1  high while a transaction is in progress.
- copi_out  output  1  serial data to the peripheral.
- dclk_out  output  1  SPI clock.
- cs_out  output  NUM_CS  chip selects, active low.

## Operation
- States: IDLE, SETUP, XFER, HOLD.
- IDLE
  - cs_out all ones; dclk_out = latched CPOL; busy_out=0.
  - trigger_in=1 with chip_sel_in < NUM_CS moves to SETUP.
  - An out-of-range chip_sel_in causes the trigger to be ignored and the block stays in IDLE.
- SETUP (HALF cycles)
  - cs_out[sel]=0, busy_out=1.
  - copi_out presents the first bit: MSB by default.
- XFER: 2·DATA_WIDTH dclk edges, one every HALF cycles. Edge k=1 is the leading edge; odd k are leading, even k are trailing.
  - CPHA=0: sample cipo_in on leading edges; shift the next bit onto copi_out on trailing edges, except the final trailing edge.
  - CPHA=1: shift on leading edges (the first leading edge shifts nothing new; copi already holds bit 0 of the order); sample on trailing edges.
  - Correction for CPHA=1: during SETUP copi_out holds the first bit, and leading edges 2..DW shift out later bits.
- HOLD (HALF cycles after the last edge): dclk_out is back at CPOL; then go to IDLE.
  - On entry to IDLE: cs_out all ones, data_out = received word, data_valid_out=1 for one cycle, busy_out=0.
- trigger_in while busy_out=1 is ignored, not queued.
- A trigger in the cycle data_valid_out=1 is accepted. Chip selects are then high for exactly that one cycle.
- data_in, mode_in and chip_sel_in may change freely after the accept cycle.
- Reset (asynchronous, any state) returns immediately to IDLE with these values:
  - cs_out all ones, dclk_out=0 (latched mode reset to 0), copi_out=0.
  - data_out=0, data_valid_out=0, busy_out=0.
  - No valid pulse is produced for an aborted transfer.

## Timing
- Accept at cycle T (trigger_in=1, busy_out=0). At T+1 the outputs are busy_out=1, cs_out[sel]=0, copi_out=first bit. All outputs are registered.
- Edge k occurs at cycle T+1+k·HALF.
- cs_out[sel] stays low for (2·DATA_WIDTH+1)·HALF cycles.
- data_valid_out fires at T+1+(2·DATA_WIDTH+1)·HALF.
- Sampling uses cipo_in as registered on the edge cycle; there is no extra synchroniser stage.

## Configuration
- SPI_LSB_FIRST_EN
  - Defined: bit order is LSB-first for both transmit and receive, and data_out is assembled LSB-first.
  - Undefined (default): MSB-first.
  - Timing is identical in both cases.

## Structure
- spi_pkg holds:
  - typedef enum spi_state_t {IDLE, SETUP, XFER, HOLD};
  - typedef logic [1:0] spi_mode_t, with CPOL/CPHA index constants;
  - localparam helpers for the CSW computation.
- Sub-module spi_clk_div:
  - HALF-cycle counter that issues an edge strobe every HALF cycles while enabled.
  - Restarts from 0 on enable.
  - Counter width $clog2(HALF+1).

## Test plan
- DW=8, DATA_CLK_PERIOD=4, mode 0, data_in=0xA5, cipo_in tied to copi_out:
  - cs_out[0] is low for 34 cycles;
  - data_out=0xA5;
  - data_valid_out pulses once, 35 cycles after accept.
- Mode 3, data_in=0x3C, cipo_in driven with 0xC3 on trailing edges:
  - dclk_out idles high;
  - data_out=0xC3.
- chip_sel_in=2: only cs_out[2] toggles. With NUM_CS=3, chip_sel_in=3 results in no transaction and busy_out stays 0.
- Second trigger mid-transfer is ignored. A trigger in the valid cycle starts the next transfer, with cs high for exactly 1 cycle.
- rst_n_in low during XFER:
  - cs_out all ones and busy_out=0 immediately;
  - no data_valid_out pulse;
  - a subsequent transfer completes normally.
- With SPI_LSB_FIRST_EN defined, data_in=0x01 in loopback: copi_out is high on the first bit; data_out=0x01.
